// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - FIFO-buffered UART transmitter with parity and 1/2 stop bits
// Break generation is compiled in only when UART_TX_BREAK_EN is defined.
module uart_tx_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [DATA_WIDTH-1:0]            iv_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [DIV_WIDTH-1:0]             iv_div,
  input  logic                             i_parity_en,
  input  logic                             i_parity_odd,
  input  logic                             i_stop2,
  input  logic                             i_break,
  output logic                             o_tx,
  output logic                             o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  ov_level
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           wr_ptr;
  logic [LW-1:0]           count;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [BW-1:0]           bit_idx;
  logic [DIV_WIDTH-1:0]    bit_cnt;
  logic [DIV_WIDTH-1:0]    div_q;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic                    stop2_q;
  logic                    stop_idx;
  logic                    tx_q;

  logic                    brk_req;
  logic                    push;
  logic                    pop;
  logic                    bit_end;
  logic                    frame_end;

`ifdef UART_TX_BREAK_EN
  assign brk_req = i_break;
`else
  logic unused_break;
  assign unused_break = i_break;
  assign brk_req      = 1'b0;
`endif

  assign o_ready   = (count != LW'(FIFO_DEPTH)) && !i_reset;
  assign push      = i_valid && o_ready;
  assign bit_end   = (bit_cnt == '0);
  assign frame_end = (state == STOP) && bit_end && (stop_idx || !stop2_q);
  // A pending break wins over the next queued word, both from IDLE and at frame end.
  assign pop       = ((state == IDLE) || frame_end) && !brk_req && (count != '0);

  assign o_tx     = tx_q | i_reset;
  assign ov_level = i_reset ? '0 : count;
  assign o_busy   = !i_reset &&
                    ((state == START) || (state == DATA) || (state == PARITY) ||
                     (state == STOP) || (count != '0));

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= iv_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      tx_q      <= 1'b1;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      bit_cnt   <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_idx  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop) begin
        // Line settings are latched here so the whole frame uses one consistent format.
        state     <= START;
        tx_q      <= 1'b0;
        shreg     <= mem[rd_ptr];
        div_q     <= iv_div;
        bit_cnt   <= iv_div;
        par_en_q  <= i_parity_en;
        par_bit_q <= (^mem[rd_ptr]) ^ i_parity_odd;
        stop2_q   <= i_stop2;
        stop_idx  <= 1'b0;
        bit_idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (brk_req) begin
              state <= BREAK;
              tx_q  <= 1'b0;
            end else begin
              tx_q  <= 1'b1;
            end
          end
          START: begin
            if (!bit_end) begin
              bit_cnt <= bit_cnt - 1'b1;
            end else begin
              bit_cnt <= div_q;
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= '0;
              state   <= DATA;
            end
          end
          DATA: begin
            if (!bit_end) begin
              bit_cnt <= bit_cnt - 1'b1;
            end else begin
              bit_cnt <= div_q;
              if (bit_idx == BW'(DATA_WIDTH - 1)) begin
                if (par_en_q) begin
                  tx_q  <= par_bit_q;
                  state <= PARITY;
                end else begin
                  tx_q     <= 1'b1;
                  stop_idx <= 1'b0;
                  state    <= STOP;
                end
              end else begin
                tx_q    <= shreg[0];
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
          PARITY: begin
            if (!bit_end) begin
              bit_cnt <= bit_cnt - 1'b1;
            end else begin
              bit_cnt  <= div_q;
              tx_q     <= 1'b1;
              stop_idx <= 1'b0;
              state    <= STOP;
            end
          end
          STOP: begin
            if (!bit_end) begin
              bit_cnt <= bit_cnt - 1'b1;
            end else if (!frame_end) begin
              bit_cnt  <= div_q;
              stop_idx <= 1'b1;
              tx_q     <= 1'b1;
            end else if (brk_req) begin
              state <= BREAK;
              tx_q  <= 1'b0;
            end else begin
              state <= IDLE;
              tx_q  <= 1'b1;
            end
          end
          BREAK: begin
            if (!brk_req) begin
              state <= IDLE;
              tx_q  <= 1'b1;
            end else begin
              tx_q  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            tx_q  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - scoreboard bench for uart_tx_buf
// Frames are decoded off o_tx and compared against words queued at push time.
module tb_uart_tx_buf;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  iv_data;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] iv_div;
  logic        i_parity_en;
  logic        i_parity_odd;
  logic        i_stop2;
  logic        i_break;
  logic        o_tx;
  logic        o_busy;
  logic [2:0]  ov_level;

  uart_tx_buf #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4),
    .DIV_WIDTH (16)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .iv_data     (iv_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .iv_div      (iv_div),
    .i_parity_en (i_parity_en),
    .i_parity_odd(i_parity_odd),
    .i_stop2     (i_stop2),
    .i_break     (i_break),
    .o_tx        (o_tx),
    .o_busy      (o_busy),
    .ov_level    (ov_level)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0]  d;
    logic [15:0] div;
    logic        pe;
    logic        po;
    logic        s2;
  } sb_entry_t;

  sb_entry_t sb[$];
  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  logic mon_en     = 1'b1;
  logic mon_busy   = 1'b0;
  int mon_start    = 0;
  int prev_end     = 0;
  int last_gap     = 0;
  int frame_len    = 0;
  int nframes      = 0;

  always @(posedge i_clk) cyc++;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [11:0] exp_frame(input logic [7:0] d, input logic pe,
                                            input logic po, input logic s2);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (pe) f[9] = (^d) ^ po;
    if (s2 && !pe) f[10] = 1'b1;
    return f;
  endfunction

  initial begin : monitor
    sb_entry_t   e;
    int          p, nb, bad, badbit;
    logic [11:0] bits, ef;
    logic [7:0]  d;
    forever begin
      @(negedge i_clk);
      if (mon_en && o_tx === 1'b0) begin
        mon_busy  = 1'b1;
        mon_start = cyc;
        last_gap  = cyc - prev_end;
        if (sb.size() == 0) begin
          check("unexpected_frame", 1, 0);
          for (int k = 0; k < 2000 && o_tx === 1'b0; k++) @(negedge i_clk);
        end else begin
          e    = sb.pop_front();
          p    = int'(e.div) + 1;
          nb   = 10 + int'(e.pe) + int'(e.s2);
          bits = '1;
          bad  = 0;
          for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < p; c++) begin
              if (b != 0 || c != 0) @(negedge i_clk);
              if (c == 0) bits[b] = o_tx;
              else if (o_tx !== bits[b]) bad++;
            end
          end
          ef     = exp_frame(e.d, e.pe, e.po, e.s2);
          badbit = 0;
          for (int b = 0; b < nb; b++) if (bits[b] !== ef[b]) badbit++;
          d = bits[8:1];
          check("frame_data", int'(d), int'(e.d));
          check("frame_bits", badbit, 0);
          check("bit_timing", bad, 0);
          frame_len = cyc - mon_start + 1;
          prev_end  = cyc;
          nframes++;
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_cfg(input logic [15:0] div, input logic pe, input logic po, input logic s2);
    iv_div       = div;
    i_parity_en  = pe;
    i_parity_odd = po;
    i_stop2      = s2;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [15:0] ediv);
    sb_entry_t e;
    int n = 0;
    iv_data = d;
    i_valid = 1'b1;
    while (!o_ready && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      check("push_timeout", 0, 1);
    end else begin
      e = '{d: d, div: ediv, pe: i_parity_en, po: i_parity_odd, s2: i_stop2};
      sb.push_back(e);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || mon_busy || o_busy) && n < 6000) begin
      @(negedge i_clk);
      n++;
    end
    check("drain", int'(n < 6000), 1);
  endtask

  task automatic wait_frame_start();
    int n = 0;
    while (!mon_busy && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    check("frame_start", int'(mon_busy), 1);
  endtask

  int st, b_cyc, lows, n0;

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    iv_data = '0;
    i_break = 1'b0;
    set_cfg(16'd3, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge i_clk);
    check("rst_tx", int'(o_tx), 1);
    check("rst_busy", int'(o_busy), 0);
    check("rst_ready", int'(o_ready), 0);
    check("rst_level", int'(ov_level), 0);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("ready_after_rst", int'(o_ready), 1);

    // 0xA5, 4 clocks per bit, even parity, one stop: 11 bits, 44 clocks
    set_cfg(16'd3, 1'b1, 1'b0, 1'b0);
    send(8'hA5, iv_div);
    wait_done();
    check("len_a5", frame_len, 44);
    check("busy_fall_a5", cyc - prev_end, 1);
    check("idle_tx", int'(o_tx), 1);

    // back-to-back frames, one clock per bit, odd parity, two stops
    set_cfg(16'd0, 1'b1, 1'b1, 1'b1);
    send(8'h3C, iv_div);
    send(8'hFF, iv_div);
    wait_done();
    check("len_b2b", frame_len, 12);
    check("no_gap_b2b", last_gap, 1);

    // fill the FIFO with continuous pushes, then one more that must stall
    set_cfg(16'd9, 1'b0, 1'b0, 1'b0);
    n0 = nframes;
    send(8'h01, iv_div);
    check("level_first", int'(ov_level), 1);
    send(8'h82, iv_div);
    check("level_push_pop", int'(ov_level), 1);
    send(8'h43, iv_div);
    check("level_3rd", int'(ov_level), 2);
    send(8'hC4, iv_div);
    check("level_4th", int'(ov_level), 3);
    send(8'h25, iv_div);
    check("level_full", int'(ov_level), 4);
    check("ready_full", int'(o_ready), 0);
    send(8'hA6, iv_div);
    wait_done();
    check("frames_fill", nframes - n0, 6);

    // reset in the middle of a frame with two words queued
    mon_en = 1'b0;
    set_cfg(16'd3, 1'b0, 1'b0, 1'b0);
    send(8'h11, iv_div);
    st = cyc + 1;
    @(negedge i_clk);
    send(8'h22, iv_div);
    check("level_q1", int'(ov_level), 1);
    send(8'h33, iv_div);
    check("level_q2", int'(ov_level), 2);
    while (cyc < st + 17) @(negedge i_clk);
    check("tx_bit3", int'(o_tx), 0);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("midrst_tx", int'(o_tx), 1);
    check("midrst_level", int'(ov_level), 0);
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_ready", int'(o_ready), 0);
    i_reset = 1'b0;
    sb.delete();
    @(negedge i_clk);
    check("midrst_ready_after", int'(o_ready), 1);
    lows = 0;
    repeat (120) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1) lows++;
    end
    check("no_frame_after_rst", lows, 0);
    check("busy_after_rst", int'(o_busy), 0);
    mon_en = 1'b1;

    // break request overlapping the end of a frame with a word queued
    set_cfg(16'd3, 1'b0, 1'b0, 1'b0);
    send(8'h55, iv_div);
    send(8'h0F, iv_div);
    wait_frame_start();
    st = mon_start;
`ifdef UART_TX_BREAK_EN
    mon_en = 1'b0;
`endif
    while (cyc < st + 30) @(negedge i_clk);
    i_break = 1'b1;
    lows = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (cyc > st + 39 && o_tx === 1'b0) lows++;
    end
    b_cyc = cyc;
    i_break = 1'b0;
`ifdef UART_TX_BREAK_EN
    check("break_low", lows, b_cyc - (st + 39));
    @(negedge i_clk);
    check("break_release", int'(o_tx), 1);
    mon_en = 1'b1;
    wait_done();
    check("break_frame_len", frame_len, 40);
`else
    wait_done();
    check("nobreak_gap", last_gap, 1);
    check("nobreak_len", frame_len, 40);
`endif

    // divisor change mid-frame only affects the next frame
    set_cfg(16'd3, 1'b0, 1'b0, 1'b0);
    send(8'hC3, 16'd3);
    send(8'h5A, 16'd7);
    wait_frame_start();
    repeat (10) @(negedge i_clk);
    iv_div = 16'd7;
    wait_done();
    check("len_div7", frame_len, 80);
    check("div_gap", last_gap, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries, power of two, >= 2.
REQ-003 SHALL have parameter DIV_WIDTH, default 16, width of the bit-period divisor.
REQ-004 SHALL have port i_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port i_reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port iv_data  in  DATA_WIDTH  word to send, LSB transmitted first.
REQ-007 SHALL have port i_valid  in  1  iv_data valid.
REQ-008 SHALL have port o_ready  out  1  FIFO can accept a word.
REQ-009 SHALL have port iv_div  in  DIV_WIDTH  clocks per bit minus one.
REQ-010 SHALL have port i_parity_en  in  1  append parity bit.
REQ-011 SHALL have port i_parity_odd  in  1  odd parity when 1, even when 0.
REQ-012 SHALL have port i_stop2  in  1  two stop bits when 1, one when 0.
REQ-013 SHALL have port i_break  in  1  break request (only with UART_TX_BREAK_EN).
REQ-014 SHALL have port o_tx  out  1  serial line, idle high.
REQ-015 SHALL have port o_busy  out  1  frame in progress or FIFO non-empty.
REQ-016 SHALL have port ov_level  out  clog2(FIFO_DEPTH+1)  FIFO occupancy.

Function
REQ-017 SHALL accept a word on any cycle with i_valid and o_ready high; ov_level increments on the next cycle.
REQ-018 SHALL drive o_ready = (ov_level != FIFO_DEPTH) and not i_reset; purely level-based, no same-cycle pop bypass.
REQ-019 SHALL drop nothing and duplicate nothing; i_valid while o_ready low is ignored.
REQ-020 SHALL use states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-021 SHALL, in IDLE with ov_level > 0, pop the head word in cycle N and drive o_tx low from cycle N+1 (START).
REQ-022 SHALL sample iv_div, i_parity_en, i_parity_odd and i_stop2 at pop; changes mid-frame do not affect the current frame.
REQ-023 SHALL hold every bit for exactly iv_div+1 clocks; iv_div = 0 gives one clock per bit.
REQ-024 SHALL send START(0), DATA_WIDTH data bits LSB first, PARITY if enabled, then 1 or 2 STOP(1) bits.
REQ-025 SHALL compute parity as XOR of data bits (even) or its inverse (odd).
REQ-026 SHALL, when the last stop bit ends and the FIFO is non-empty, pop and start the next START bit on the immediately following clock with no idle gap.
REQ-027 SHALL, on simultaneous push and pop, leave ov_level unchanged.
REQ-028 SHALL hold o_tx high in IDLE.

Reset
REQ-029 SHALL, while i_reset is high, force o_tx=1, o_busy=0, o_ready=0, ov_level=0, state IDLE.
REQ-030 SHALL, on reset mid-frame, drive o_tx=1 on the next clock, discard the current frame and flush the FIFO.
REQ-031 SHALL present o_ready=1 on the first cycle after i_reset falls.

Configuration
REQ-032 SHALL compile break support only when macro UART_TX_BREAK_EN is defined.
REQ-033 SHALL, with UART_TX_BREAK_EN, enter BREAK from IDLE (or after the current frame's last stop bit) while i_break is high, hold o_tx low, hold FIFO pops, and return to IDLE the clock after i_break falls; i_break has priority over a pending pop.
REQ-034 SHALL, without UART_TX_BREAK_EN, ignore i_break and never enter BREAK.

Verification
REQ-035 SHALL cover: DATA_WIDTH=8, iv_div=3, parity even, 1 stop, push 0xA5 -> o_tx = 0,1,0,1,0,0,1,0,1,0,1 each 4 clocks, 44 clocks total, o_busy low after.
REQ-036 SHALL cover: push 0x3C, 0xFF back-to-back, iv_div=0, parity odd, 2 stop -> 24 consecutive bits, second start bit immediately after fourth... stop bit, no idle cycle, odd parity bits 1 and 1.
REQ-037 SHALL cover: FIFO_DEPTH=4, iv_div=9, push 5 words continuously -> o_ready low on cycle after 4th accept once pop not yet occurred; all 5 words serialised in order, none lost.
REQ-038 SHALL cover: assert i_reset at bit 3 of a frame with 2 words queued -> o_tx=1 next clock, ov_level=0, o_busy=0, no further frame.
REQ-039 SHALL cover: with UART_TX_BREAK_EN, i_break high for 20 clocks during a frame -> frame completes, o_tx low exactly while i_break high afterwards, queued word sent after release; without macro, same stimulus -> no break.
REQ-040 SHALL cover: change iv_div from 3 to 7 mid-frame -> current frame keeps 4-clock bits, next frame uses 8-clock bits.
